// File: rtl/regfile_sb.sv
// Parametrised register file with write-to-read bypass and a per-register busy
// scoreboard for the decode-stage hazard unit. Register 0 reads zero and is never busy.
module regfile_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS),
  parameter int NUM_RD     = 2,
  parameter bit BYPASS_EN  = 1'b1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         rd_wren,
  input  logic [ADDR_WIDTH-1:0]        rd_addr,
  input  logic [DATA_WIDTH-1:0]        rd_data,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rs_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rs_data,
  output logic [NUM_RD-1:0]            rs_busy,
  input  logic                         issue_valid,
  input  logic [ADDR_WIDTH-1:0]        issue_rd,
  output logic [NUM_REGS-1:0]          busy_vec
);

  // issue_valid has no ready: every issue is accepted on the edge it is presented,
  // and every writeback is accepted likewise; neither side can be stalled here.

  logic [DATA_WIDTH-1:0] regs [1:NUM_REGS-1];
  logic [DATA_WIDTH-1:0] reg_view [NUM_REGS];
  logic [NUM_REGS-1:1]   busy_q;
  logic [NUM_REGS-1:1]   busy_nxt;
  logic [NUM_REGS-1:1]   wr_sel;
  logic [NUM_REGS-1:1]   iss_sel;
  logic                  wr_en;

  assign wr_en = rd_wren && (rd_addr != '0);

  always_comb begin
    wr_sel  = '0;
    iss_sel = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      wr_sel[i]  = rd_wren && (rd_addr == ADDR_WIDTH'(i));
      iss_sel[i] = issue_valid && (issue_rd == ADDR_WIDTH'(i));
    end
  end

  // Set wins over clear: a new producer supersedes the one retiring this cycle.
  always_comb begin
    busy_nxt = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      busy_nxt[i] = iss_sel[i] | (busy_q[i] & ~wr_sel[i]);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (wr_sel[i]) begin
          regs[i] <= rd_data;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_nxt;
    end
  end

  always_comb begin
    reg_view[0] = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      reg_view[i] = regs[i];
    end
  end

  assign busy_vec = {busy_q, 1'b0};

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr;
    logic                  hit;

    assign addr = rs_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
    // Forwarding is suppressed in reset so outputs read all-zero while rst_i is high.
    assign hit  = BYPASS_EN && !rst_i && wr_en && (rd_addr == addr);
    assign rs_data[k*DATA_WIDTH +: DATA_WIDTH] = hit ? rd_data : reg_view[addr];
    assign rs_busy[k] = hit ? 1'b0 : busy_vec[addr];
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: hand-computed vector table on the default build, reset and
// no-bypass sequences, and a randomised model comparison on a 4-port 16x64 build.
module tb_regfile_sb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Instance A: default parameters, bypass on
  logic        a_wren;
  logic [4:0]  a_waddr;
  logic [31:0] a_wdata;
  logic [9:0]  a_rs_addr;
  logic [63:0] a_rs_data;
  logic [1:0]  a_rs_busy;
  logic        a_iv;
  logic [4:0]  a_ird;
  logic [31:0] a_bvec;

  // Instance B: bypass off
  logic        b_wren;
  logic [4:0]  b_waddr;
  logic [31:0] b_wdata;
  logic [9:0]  b_rs_addr;
  logic [63:0] b_rs_data;
  logic [1:0]  b_rs_busy;
  logic        b_iv;
  logic [4:0]  b_ird;
  logic [31:0] b_bvec;

  // Instance C: 4 read ports, 16 x 64-bit
  logic         c_wren;
  logic [3:0]   c_waddr;
  logic [63:0]  c_wdata;
  logic [15:0]  c_rs_addr;
  logic [255:0] c_rs_data;
  logic [3:0]   c_rs_busy;
  logic         c_iv;
  logic [3:0]   c_ird;
  logic [15:0]  c_bvec;

  regfile_sb u_a (
    .clk_i(clk), .rst_i(rst), .rd_wren(a_wren), .rd_addr(a_waddr), .rd_data(a_wdata),
    .rs_addr(a_rs_addr), .rs_data(a_rs_data), .rs_busy(a_rs_busy),
    .issue_valid(a_iv), .issue_rd(a_ird), .busy_vec(a_bvec)
  );

  regfile_sb #(.BYPASS_EN(1'b0)) u_b (
    .clk_i(clk), .rst_i(rst), .rd_wren(b_wren), .rd_addr(b_waddr), .rd_data(b_wdata),
    .rs_addr(b_rs_addr), .rs_data(b_rs_data), .rs_busy(b_rs_busy),
    .issue_valid(b_iv), .issue_rd(b_ird), .busy_vec(b_bvec)
  );

  regfile_sb #(.DATA_WIDTH(64), .NUM_REGS(16), .NUM_RD(4)) u_c (
    .clk_i(clk), .rst_i(rst), .rd_wren(c_wren), .rd_addr(c_waddr), .rd_data(c_wdata),
    .rs_addr(c_rs_addr), .rs_data(c_rs_data), .rs_busy(c_rs_busy),
    .issue_valid(c_iv), .issue_rd(c_ird), .busy_vec(c_bvec)
  );

  typedef struct {
    logic        wren;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        iv;
    logic [4:0]  ird;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] ed0;
    logic [31:0] ed1;
    logic [1:0]  eb;
    logic [31:0] ebv;
  } vec_t;

  vec_t tbl [19];

  logic [275:0] exp_q [$];

  logic [63:0] m_regs [16];
  logic [15:0] m_busy;

  task automatic check(input string name, input logic [275:0] act, input logic [275:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_all();
    a_wren = 1'b0; a_waddr = '0; a_wdata = '0; a_rs_addr = '0; a_iv = 1'b0; a_ird = '0;
    b_wren = 1'b0; b_waddr = '0; b_wdata = '0; b_rs_addr = '0; b_iv = 1'b0; b_ird = '0;
    c_wren = 1'b0; c_waddr = '0; c_wdata = '0; c_rs_addr = '0; c_iv = 1'b0; c_ird = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Expected values are derived by hand, row by row, from the state left by earlier rows.
  task automatic init_tbl();
    //          wren  wa     wd             iv    ird    ra0    ra1    ed0            ed1            eb     ebv
    tbl[0]  = '{1'b1, 5'd1,  32'h0000_00AA, 1'b0, 5'd0,  5'd1,  5'd31, 32'h0000_00AA, 32'h0,         2'b00, 32'h0};
    tbl[1]  = '{1'b1, 5'd31, 32'hFFFF_FFFF, 1'b0, 5'd0,  5'd1,  5'd31, 32'h0000_00AA, 32'hFFFF_FFFF, 2'b00, 32'h0};
    tbl[2]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd1,  5'd31, 32'h0000_00AA, 32'hFFFF_FFFF, 2'b00, 32'h0};
    tbl[3]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd3,  5'd3,  5'd1,  32'h0,         32'h0000_00AA, 2'b00, 32'h0};
    tbl[4]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd3,  5'd3,  32'h0,         32'h0,         2'b11, 32'h8};
    tbl[5]  = '{1'b1, 5'd3,  32'h33,        1'b0, 5'd0,  5'd3,  5'd0,  32'h33,        32'h0,         2'b00, 32'h8};
    tbl[6]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd0,  5'd3,  5'd3,  32'h33,        32'h33,        2'b00, 32'h0};
    tbl[7]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd0,  5'd3,  32'h0,         32'h33,        2'b00, 32'h0};
    tbl[8]  = '{1'b1, 5'd0,  32'h1234_5678, 1'b0, 5'd0,  5'd0,  5'd0,  32'h0,         32'h0,         2'b00, 32'h0};
    tbl[9]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd0,  5'd1,  32'h0,         32'h0000_00AA, 2'b00, 32'h0};
    tbl[10] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd7,  5'd7,  5'd7,  32'h0,         32'h0,         2'b00, 32'h0};
    tbl[11] = '{1'b1, 5'd7,  32'h55,        1'b0, 5'd0,  5'd7,  5'd7,  32'h55,        32'h55,        2'b00, 32'h80};
    tbl[12] = '{1'b1, 5'd4,  32'h99,        1'b1, 5'd4,  5'd4,  5'd7,  32'h99,        32'h55,        2'b00, 32'h0};
    tbl[13] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd9,  5'd4,  5'd4,  32'h99,        32'h99,        2'b11, 32'h10};
    tbl[14] = '{1'b1, 5'd9,  32'h909,       1'b1, 5'd6,  5'd9,  5'd6,  32'h909,       32'h0,         2'b00, 32'h210};
    tbl[15] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd9,  5'd6,  32'h909,       32'h0,         2'b10, 32'h50};
    tbl[16] = '{1'b1, 5'd4,  32'h44,        1'b0, 5'd0,  5'd4,  5'd2,  32'h44,        32'h0,         2'b00, 32'h50};
    tbl[17] = '{1'b1, 5'd2,  32'h22,        1'b0, 5'd0,  5'd2,  5'd4,  32'h22,        32'h44,        2'b00, 32'h40};
    tbl[18] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd2,  5'd6,  32'h22,        32'h0,         2'b10, 32'h40};
  endtask

  initial begin
    logic [255:0] ed;
    logic [3:0]   eb;
    logic [3:0]   a;
    logic [3:0]   shared;
    logic         hit;
    logic [15:0]  nb;
    logic [275:0] exp_v;
    int           mode;

    idle_all();
    init_tbl();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_busy = '0;

    // Reset state, with write/issue/bypass stimulus presented during reset
    #2;
    a_wren = 1'b1; a_waddr = 5'd5; a_wdata = 32'hCAFE_F00D; a_iv = 1'b1; a_ird = 5'd5;
    a_rs_addr = {5'd5, 5'd5};
    #1;
    check("reset_rs_data", a_rs_data, 64'h0);
    check("reset_rs_busy", a_rs_busy, 2'b00);
    check("reset_busy_vec", a_bvec, 32'h0);
    next_cycle();
    idle_all();
    rst = 1'b0;
    a_rs_addr = {5'd5, 5'd5};
    #3;
    check("post_reset_dropped_write", a_rs_data, 64'h0);
    check("post_reset_dropped_issue", a_bvec, 32'h0);
    next_cycle();

    // Table of hand-computed vectors on instance A
    for (int i = 0; i < 19; i++) begin
      a_wren = tbl[i].wren; a_waddr = tbl[i].wa; a_wdata = tbl[i].wd;
      a_iv = tbl[i].iv; a_ird = tbl[i].ird;
      a_rs_addr = {tbl[i].ra1, tbl[i].ra0};
      #3;
      check($sformatf("tbl%0d_rs_data0", i), a_rs_data[31:0], tbl[i].ed0);
      check($sformatf("tbl%0d_rs_data1", i), a_rs_data[63:32], tbl[i].ed1);
      check($sformatf("tbl%0d_rs_busy", i), a_rs_busy, tbl[i].eb);
      check($sformatf("tbl%0d_busy_vec", i), a_bvec, tbl[i].ebv);
      next_cycle();
    end
    idle_all();

    // Asynchronous reset mid-cycle after writing x5
    a_wren = 1'b1; a_waddr = 5'd5; a_wdata = 32'hDEAD_BEEF; a_iv = 1'b1; a_ird = 5'd5;
    next_cycle();
    a_wren = 1'b0; a_iv = 1'b0; a_rs_addr = {5'd0, 5'd5};
    #1;
    check("x5_before_reset", a_rs_data[31:0], 32'hDEAD_BEEF);
    check("x5_busy_before_reset", a_bvec, 32'h60);
    #2;
    rst = 1'b1;
    #1;
    check("x5_async_reset", a_rs_data[31:0], 32'h0);
    check("busy_vec_async_reset", a_bvec, 32'h0);
    a_wren = 1'b1; a_waddr = 5'd5; a_wdata = 32'h0000_1234; a_iv = 1'b1; a_ird = 5'd5;
    a_rs_addr = {5'd5, 5'd5};
    #1;
    check("no_bypass_in_reset", a_rs_data, 64'h0);
    check("no_rs_busy_in_reset", a_rs_busy, 2'b00);
    next_cycle();
    check("edge_in_reset_data", a_rs_data, 64'h0);
    check("edge_in_reset_busy", a_bvec, 32'h0);
    a_wren = 1'b0; a_iv = 1'b0;
    #2;
    rst = 1'b0;
    next_cycle();
    check("after_reset_x5", a_rs_data, 64'h0);
    check("after_reset_busy_vec", a_bvec, 32'h0);
    idle_all();

    // Bypass disabled: old value same cycle, new value next cycle
    b_iv = 1'b1; b_ird = 5'd7;
    #3;
    check("nobyp_busy_before_issue", b_bvec, 32'h0);
    next_cycle();
    b_iv = 1'b0;
    b_wren = 1'b1; b_waddr = 5'd7; b_wdata = 32'h55; b_rs_addr = {5'd7, 5'd7};
    #3;
    check("nobyp_old_value", b_rs_data, 64'h0);
    check("nobyp_busy_visible", b_rs_busy, 2'b11);
    check("nobyp_busy_vec", b_bvec, 32'h80);
    next_cycle();
    b_wren = 1'b0;
    #3;
    check("nobyp_new_value", b_rs_data, {32'h55, 32'h55});
    check("nobyp_busy_cleared", b_bvec, 32'h0);
    next_cycle();
    idle_all();

    // Randomised sweep on the 4-port 16 x 64-bit build against a reference model
    for (int cyc = 0; cyc < 5000; cyc++) begin
      c_wren  = ($urandom_range(0, 3) != 0);
      c_waddr = 4'($urandom_range(0, 15));
      c_wdata = {$urandom, $urandom};
      c_iv    = ($urandom_range(0, 3) != 0);
      c_ird   = 4'($urandom_range(0, 15));
      mode    = $urandom_range(0, 3);
      shared  = 4'($urandom_range(0, 15));
      for (int k = 0; k < 4; k++) begin
        case (mode)
          0:       c_rs_addr[k*4 +: 4] = shared;
          1:       c_rs_addr[k*4 +: 4] = c_waddr;
          default: c_rs_addr[k*4 +: 4] = 4'($urandom_range(0, 15));
        endcase
      end
      for (int k = 0; k < 4; k++) begin
        a   = c_rs_addr[k*4 +: 4];
        hit = c_wren && (c_waddr != 4'd0) && (c_waddr == a);
        ed[k*64 +: 64] = hit ? c_wdata : m_regs[a];
        eb[k]          = hit ? 1'b0 : m_busy[a];
      end
      exp_q.push_back({ed, eb, m_busy});
      #3;
      exp_v = exp_q.pop_front();
      check($sformatf("sweep_cyc%0d", cyc), {c_rs_data, c_rs_busy, c_bvec}, exp_v);
      nb = m_busy;
      if (c_wren && c_waddr != 4'd0) begin
        m_regs[c_waddr] = c_wdata;
        nb[c_waddr]     = 1'b0;
      end
      if (c_iv && c_ird != 4'd0) nb[c_ird] = 1'b1;
      m_busy = nb;
      next_cycle();
    end
    idle_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
